ad4008_responder: RTL and testbench

Synthesizable device-side model of the AD4008 3-wire serial ADC interface (CNV, SCK, SDO, no busy indicator), running entirely on the system clock. It captures a parallel sample word on each CNV rising edge, models the conversion time, and shifts the result MSB-first on SDO as the reader toggles SCK. It is used for on-board loopback of the AD4008 read path and as a hardware stand-in when no ADC is fitted.

---
 rtl/ad4008_pkg.sv | 21 ++
 rtl/ad4008_responder_pin_edge_sync.sv | 36 +++
 rtl/ad4008_responder.sv | 133 +++++++++++++
 tb/tb_ad4008_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ad4008_pkg.sv
// Shared types and constants for the AD4008 device-side responder.
package ad4008_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WAIT_READ,
    ST_SHIFT,
    ST_DONE
  } ad4008_state_t;

  localparam int AD4008_WIDTH     = 16;
  localparam int AD4008_T_CONV_NS = 290;

  // Conversion time in clk cycles, rounded up so the model is never faster
  // than the real part.
  function automatic int ad4008_conv_cycles(input int clk_period_ns);
    return (AD4008_T_CONV_NS + clk_period_ns - 1) / clk_period_ns;
  endfunction

endpackage

// File: rtl/ad4008_responder_pin_edge_sync.sv
// Synchronizer chain plus registered level for one asynchronous pin.
// rise/fall are combinational against the registered level, so an action
// taken on them lands SYNC_STAGES+1 edges after the pin moves.
module pin_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sreset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  // Shift the pin through the synchronizer and keep the last settled level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop in the chain sample its
    // pre-edge input; blocking ones would collapse the chain into one stage.
    if (sreset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      level_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~level_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & level_q;

endmodule

// File: rtl/ad4008_responder.sv
// Device-side model of the AD4008 3-wire read path (CNV, SCK, SDO).
// Captures sample_data on CNV rise, waits the conversion time, then shifts the
// result MSB-first on each SCK fall once CNV has dropped.
module ad4008_responder
  import ad4008_pkg::*;
#(
  parameter int ADC_WIDTH   = AD4008_WIDTH,
  parameter int CONV_CYCLES = ad4008_conv_cycles(20),
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic [ADC_WIDTH-1:0] sample_data,
  input  logic                 cnv,
  input  logic                 sck,
  output logic                 sdo,
  output logic                 sdo_oe,
  output logic                 frame_done,
  output logic                 conv_violation,
  output logic                 overrun
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BW = $clog2(ADC_WIDTH + 1);
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(ADC_WIDTH - 1);

  ad4008_state_t state_q, state_d;

  logic [ADC_WIDTH-1:0] cap_reg, result_reg, shift_reg;
  logic [CW-1:0]        conv_cnt;
  logic [BW-1:0]        bit_cnt;

  logic cnv_rise, cnv_fall, sck_fall;
  // SCK rising edges carry no action in this device.
  logic sck_rise_unused;

  pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
    .clk    (clk),
    .sreset (sreset),
    .pin    (cnv),
    .rise   (cnv_rise),
    .fall   (cnv_fall)
  );

  pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .sreset (sreset),
    .pin    (sck),
    .rise   (sck_rise_unused),
    .fall   (sck_fall)
  );

  // Events shared by the next-state logic and the datapath. A CNV rise
  // overrides all of them, which both processes enforce by checking it first.
  logic start_shift, conv_done, shift_step, last_bit;

  assign start_shift = cnv_fall && (state_q == ST_CONVERT || state_q == ST_WAIT_READ);
  assign conv_done   = (state_q == ST_CONVERT) && !cnv_fall && (conv_cnt == '0);
  assign shift_step  = (state_q == ST_SHIFT) && sck_fall;
  assign last_bit    = shift_step && (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (sreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; CNV rise restarts from any state.
  always_comb begin
    // NOTE: state_d takes a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (cnv_rise)         state_d = ST_CONVERT;
    else if (start_shift) state_d = ST_SHIFT;
    else if (conv_done)   state_d = ST_WAIT_READ;
    else if (last_bit)    state_d = ST_DONE;
  end

  // Registered datapath and outputs: capture, conversion timer, shifter, pulses.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a plain flop, data holds included, so all
    // of them clear on reset; there is no RAM that would need to be left alone.
    if (sreset) begin
      cap_reg        <= '0;
      result_reg     <= '0;
      shift_reg      <= '0;
      conv_cnt       <= '0;
      bit_cnt        <= '0;
      sdo            <= 1'b0;
      sdo_oe         <= 1'b0;
      frame_done     <= 1'b0;
      conv_violation <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frame_done     <= 1'b0;
      conv_violation <= 1'b0;
      overrun        <= 1'b0;
      if (cnv_rise) begin
        cap_reg        <= sample_data;
        conv_cnt       <= CONV_LOAD;
        sdo_oe         <= 1'b0;
        sdo            <= 1'b0;
        overrun        <= (state_q == ST_SHIFT);
        conv_violation <= (state_q == ST_CONVERT);
      end else begin
        if (state_q == ST_CONVERT && !cnv_fall) begin
          if (conv_cnt == '0) result_reg <= cap_reg;
          else                conv_cnt   <= conv_cnt - 1'b1;
        end
        // An early CNV fall drives the previous result, which is still held.
        if (start_shift) begin
          shift_reg      <= result_reg;
          sdo_oe         <= 1'b1;
          sdo            <= result_reg[ADC_WIDTH-1];
          bit_cnt        <= '0;
          conv_violation <= (state_q == ST_CONVERT);
        end
        if (shift_step) begin
          shift_reg <= {shift_reg[ADC_WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + 1'b1;
          if (last_bit) begin
            sdo        <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            sdo <= shift_reg[ADC_WIDTH-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ad4008_responder.sv
// Directed bench for ad4008_responder: reads frames through the CNV/SCK pins
// exactly as an external reader would and compares against hand-computed words.
module tb_ad4008_responder;
  import ad4008_pkg::*;

  logic        clk = 1'b0;
  logic        sreset;
  logic [15:0] sample_data;
  logic        cnv;
  logic        sck;
  logic        sdo;
  logic        sdo_oe;
  logic        frame_done;
  logic        conv_violation;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int ov_cnt = 0;
  int cv_cnt = 0;
  logic [31:0] word;

  always #5 clk = ~clk;

  ad4008_responder dut (
    .clk            (clk),
    .sreset         (sreset),
    .sample_data    (sample_data),
    .cnv            (cnv),
    .sck            (sck),
    .sdo            (sdo),
    .sdo_oe         (sdo_oe),
    .frame_done     (frame_done),
    .conv_violation (conv_violation),
    .overrun        (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clk and sample outputs 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done)     fd_cnt++;
      if (overrun)        ov_cnt++;
      if (conv_violation) cv_cnt++;
    end
  endtask

  task automatic clear_counts();
    fd_cnt = 0;
    ov_cnt = 0;
    cv_cnt = 0;
  endtask

  // CNV high for high_cycles (sample_data scrambled after the capture point),
  // then low long enough for the fall to reach the shifter.
  task automatic convert(input string tag, input logic [15:0] data, input int high_cycles);
    sample_data = data;
    cnv = 1'b1;
    for (int i = 0; i < high_cycles; i++) begin
      tick();
      if (i == 4) sample_data = ~data;
    end
    check(tag, sdo_oe, 1'b0);
    cnv = 1'b0;
    tick(4);
  endtask

  // nbits SCK periods of 8 clk; SDO sampled late in the high phase.
  task automatic read_bits(input int nbits, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b1;
      tick(4);
      w = {w[30:0], sdo};
      sck = 1'b0;
      tick(4);
    end
  endtask

  initial begin
    sreset      = 1'b1;
    cnv         = 1'b0;
    sck         = 1'b0;
    sample_data = '0;
    tick(3);
    check("rst_sdo", sdo, 1'b0);
    check("rst_oe", sdo_oe, 1'b0);
    check("rst_pulses", {frame_done, conv_violation, overrun}, 3'b000);
    sreset = 1'b0;
    tick(2);

    // Nominal frame.
    clear_counts();
    convert("nom_oe_cnv_high", 16'hAAAA, 20);
    check("nom_oe_read", sdo_oe, 1'b1);
    read_bits(16, word);
    check("nom_word", word, 32'h0000_AAAA);
    check("nom_frame_done", fd_cnt, 1);
    check("nom_sdo_after", sdo, 1'b0);
    check("nom_oe_after", sdo_oe, 1'b1);
    check("nom_no_viol", cv_cnt, 0);

    // Back-to-back frames.
    clear_counts();
    convert("b2b_oe_a", 16'h00F0, 20);
    read_bits(16, word);
    check("b2b_word_a", word, 32'h0000_00F0);
    convert("b2b_oe_b", 16'hFFFF, 20);
    read_bits(16, word);
    check("b2b_word_b", word, 32'h0000_FFFF);
    check("b2b_frame_done", fd_cnt, 2);

    // Early CNV fall returns the previous result.
    convert("early_prev_oe", 16'h1234, 20);
    read_bits(16, word);
    check("early_prev_word", word, 32'h0000_1234);
    clear_counts();
    convert("early_oe", 16'h5678, 5);
    check("early_viol", cv_cnt, 1);
    read_bits(16, word);
    check("early_word", word, 32'h0000_1234);
    check("early_frame_done", fd_cnt, 1);

    // Overrun: new CNV rise after 7 SCK falls.
    convert("ovr_first_oe", 16'hC3A5, 20);
    clear_counts();
    read_bits(7, word);
    check("ovr_partial", word, 32'h0000_0061);
    sample_data = 16'h5A3C;
    cnv = 1'b1;
    tick(4);
    check("ovr_oe_drop", sdo_oe, 1'b0);
    check("ovr_pulse", ov_cnt, 1);
    check("ovr_no_done", fd_cnt, 0);
    check("ovr_no_viol", cv_cnt, 0);
    tick(16);
    cnv = 1'b0;
    tick(4);
    read_bits(16, word);
    check("ovr_next_word", word, 32'h0000_5A3C);
    check("ovr_next_done", fd_cnt, 1);

    // Extra SCK periods read zeros and do not repeat frame_done.
    clear_counts();
    convert("extra_oe", 16'h9C6B, 20);
    read_bits(20, word);
    check("extra_word", word, 32'h0009_C6B0);
    check("extra_frame_done", fd_cnt, 1);
    check("extra_sdo_after", sdo, 1'b0);

    // Reset mid-shift with CNV held high through reset.
    clear_counts();
    convert("rst_mid_oe", 16'h0F0F, 20);
    read_bits(5, word);
    check("rst_mid_partial", word, 32'h0000_0001);
    sample_data = 16'h6E19;
    cnv    = 1'b1;
    sreset = 1'b1;
    tick();
    check("rst_mid_oe_low", sdo_oe, 1'b0);
    check("rst_mid_sdo_low", sdo, 1'b0);
    tick(2);
    sreset = 1'b0;
    tick(2);
    check("rst_state_t2", 32'(dut.state_q), 32'(ST_IDLE));
    tick();
    check("rst_state_t3", 32'(dut.state_q), 32'(ST_CONVERT));
    tick(17);
    cnv = 1'b0;
    tick(4);
    read_bits(16, word);
    check("rst_word", word, 32'h0000_6E19);
    check("rst_frame_done", fd_cnt, 1);
    check("rst_no_ovr", ov_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
